// File: rtl/trigger_qualifier_if.sv
// Trigger/done handshake between the qualifier
// and the glitch pulse stage.
interface trigger_qualifier_if;
  logic trigger_out;
  logic done_in;

  modport master (
    output trigger_out,
    input  done_in
  );

  modport slave (
    input  trigger_out,
    output done_in
  );
endinterface

// File: rtl/trigger_qualifier.sv
// Trigger qualifier: sync, spike filter, N-edge arm,
// level handshake with glitch stage, re-trigger holdoff.
module trigger_qualifier #(
  parameter int unsigned FILTER_CYCLES  = 8,
  parameter int unsigned EDGE_COUNT     = 1,
  parameter int unsigned HOLDOFF_CYCLES = 1024,
  parameter int unsigned DONE_TIMEOUT   = 0,
  parameter int unsigned INVERT         = 0,
  parameter int unsigned ONESHOT        = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                trig_in,
  input  logic                arm,
  trigger_qualifier_if.master hs,
  output logic                armed_indicator,
  output logic                fired_indicator,
  output logic                fault
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    FIRE,
    HOLDOFF
  } state_t;

  localparam logic [7:0]  F_LAST = 8'(FILTER_CYCLES - 1);
  localparam logic [7:0]  F_SAT  = 8'(FILTER_CYCLES);
  localparam logic [15:0] E_LAST = 16'(EDGE_COUNT - 1);
  localparam logic [31:0] T_LAST = DONE_TIMEOUT - 32'd1;
  localparam logic [31:0] H_LAST =
    (HOLDOFF_CYCLES == 0) ? 32'd0 : HOLDOFF_CYCLES - 32'd1;
  localparam logic INV    = (INVERT != 0);
  localparam logic TMO_EN = (DONE_TIMEOUT != 0);
  localparam logic REARM  = (ONESHOT == 0);

  if (FILTER_CYCLES < 1 || FILTER_CYCLES > 255 ||
      EDGE_COUNT < 1 || EDGE_COUNT > 65535 ||
      INVERT > 1 || ONESHOT > 1) begin : g_bad_param
    $error("trigger_qualifier: parameter out of range");
  end

  state_t      state;
  logic        sync1;
  logic        sync2;
  logic        trig_s;
  logic        arm_d;
  logic [7:0]  stable;
  logic [15:0] edge_cnt;
  logic [31:0] tmo_cnt;
  logic [31:0] hold_cnt;
  logic        qual;
  logic        arm_rise;

  // qual fires once, on the cycle the run reaches FILTER_CYCLES
  assign qual     = trig_s && (stable == F_LAST);
  assign arm_rise = arm && !arm_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      sync1           <= 1'b0;
      sync2           <= 1'b0;
      trig_s          <= 1'b0;
      arm_d           <= 1'b0;
      stable          <= 8'd0;
      edge_cnt        <= 16'd0;
      tmo_cnt         <= 32'd0;
      hold_cnt        <= 32'd0;
      hs.trigger_out  <= 1'b0;
      armed_indicator <= 1'b0;
      fired_indicator <= 1'b0;
      fault           <= 1'b0;
    end else begin
      sync1  <= trig_in;
      sync2  <= sync1;
      trig_s <= sync2 ^ INV;
      arm_d  <= arm;

      if (!trig_s)
        stable <= 8'd0;
      else if (stable != F_SAT)
        stable <= stable + 8'd1;

      unique case (state)
        IDLE: begin
          if (arm_rise) begin
            state           <= ARMED;
            armed_indicator <= 1'b1;
            fired_indicator <= 1'b0;
            fault           <= 1'b0;
            edge_cnt        <= 16'd0;
          end
        end
        ARMED: begin
          if (!arm) begin
            state           <= IDLE;
            armed_indicator <= 1'b0;
            edge_cnt        <= 16'd0;
          end else if (qual) begin
            if (edge_cnt == E_LAST) begin
              state           <= FIRE;
              armed_indicator <= 1'b0;
              hs.trigger_out  <= 1'b1;
              fired_indicator <= 1'b1;
              tmo_cnt         <= 32'd0;
            end else begin
              edge_cnt <= edge_cnt + 16'd1;
            end
          end
        end
        FIRE: begin
          if (hs.done_in) begin
            state          <= HOLDOFF;
            hs.trigger_out <= 1'b0;
            hold_cnt       <= 32'd0;
          end else if (TMO_EN && tmo_cnt == T_LAST) begin
            state          <= HOLDOFF;
            hs.trigger_out <= 1'b0;
            fault          <= 1'b1;
            hold_cnt       <= 32'd0;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        HOLDOFF: begin
          if (hold_cnt == H_LAST) begin
            if (REARM && arm) begin
              state           <= ARMED;
              armed_indicator <= 1'b1;
              edge_cnt        <= 16'd0;
            end else begin
              state <= IDLE;
            end
          end else begin
            hold_cnt <= hold_cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trigger_qualifier.sv
// Bench for trigger_qualifier: five configurations
// against a behavioural model plus directed checks.
module tb_trigger_qualifier;

  localparam int N = 5;
  localparam int S_IDLE = 0;
  localparam int S_ARM  = 1;
  localparam int S_FIRE = 2;
  localparam int S_HOLD = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         trig;
  logic         done;
  logic [N-1:0] arm_v;
  logic [N-1:0] o_trig;
  logic [N-1:0] o_armed;
  logic [N-1:0] o_fired;
  logic [N-1:0] o_fault;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit chk_en   = 0;

  function automatic int p_f(int g);
    return 8;
  endfunction
  function automatic int p_e(int g);
    return (g == 1) ? 3 : 1;
  endfunction
  function automatic int p_h(int g);
    return (g == 1) ? 8 : (g == 2) ? 16 : 1024;
  endfunction
  function automatic int p_t(int g);
    return (g == 3) ? 100 : 0;
  endfunction
  function automatic bit p_i(int g);
    return (g == 4);
  endfunction
  function automatic bit p_o(int g);
    return (g != 2);
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    trigger_qualifier_if hs();
    assign hs.done_in = done;
    assign o_trig[g]  = hs.trigger_out;
    trigger_qualifier #(
      .FILTER_CYCLES (p_f(g)),
      .EDGE_COUNT    (p_e(g)),
      .HOLDOFF_CYCLES(p_h(g)),
      .DONE_TIMEOUT  (p_t(g)),
      .INVERT        (int'(p_i(g))),
      .ONESHOT       (int'(p_o(g)))
    ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .trig_in        ((g == 4) ? ~trig : trig),
      .arm            (arm_v[g]),
      .hs             (hs),
      .armed_indicator(o_armed[g]),
      .fired_indicator(o_fired[g]),
      .fault          (o_fault[g])
    );
  end

  // model: raw samples delayed 3 edges, then run-length rule
  int m_st  [N];
  bit m_fir [N];
  bit m_flt [N];
  bit m_parm[N];
  int m_run [N];
  bit m_hist[N][3];
  int m_ecnt[N];
  int m_tcnt[N];
  int m_hcnt[N];

  task automatic model_step(input int i);
    bit raw, a, qual, rise;
    int hlen;
    raw = (i == 4) ? ~trig : trig;
    if (!rst_n) begin
      m_st[i] = S_IDLE;
      m_fir[i] = 0;
      m_flt[i] = 0;
      m_parm[i] = 0;
      m_run[i] = 0;
      m_hist[i][0] = 0;
      m_hist[i][1] = 0;
      m_hist[i][2] = p_i(i);
      m_ecnt[i] = 0;
      m_tcnt[i] = 0;
      m_hcnt[i] = 0;
      return;
    end
    a = m_hist[i][2] ^ p_i(i);
    if (!a) m_run[i] = 0;
    else if (m_run[i] < 1000) m_run[i]++;
    qual = a && (m_run[i] == p_f(i));
    m_hist[i][2] = m_hist[i][1];
    m_hist[i][1] = m_hist[i][0];
    m_hist[i][0] = raw;
    rise = arm_v[i] && !m_parm[i];
    m_parm[i] = arm_v[i];
    hlen = (p_h(i) == 0) ? 1 : p_h(i);
    case (m_st[i])
      S_IDLE:
        if (rise) begin
          m_st[i] = S_ARM;
          m_fir[i] = 0;
          m_flt[i] = 0;
          m_ecnt[i] = 0;
        end
      S_ARM:
        if (!arm_v[i]) begin
          m_st[i] = S_IDLE;
        end else if (qual) begin
          if (m_ecnt[i] == p_e(i) - 1) begin
            m_st[i] = S_FIRE;
            m_fir[i] = 1;
            m_tcnt[i] = 0;
          end else begin
            m_ecnt[i]++;
          end
        end
      S_FIRE: begin
        m_tcnt[i]++;
        if (done) begin
          m_st[i] = S_HOLD;
          m_hcnt[i] = 0;
        end else if (p_t(i) != 0 && m_tcnt[i] == p_t(i)) begin
          m_st[i] = S_HOLD;
          m_flt[i] = 1;
          m_hcnt[i] = 0;
        end
      end
      default: begin
        m_hcnt[i]++;
        if (m_hcnt[i] >= hlen) begin
          if (!p_o(i) && arm_v[i]) begin
            m_st[i] = S_ARM;
            m_ecnt[i] = 0;
          end else begin
            m_st[i] = S_IDLE;
          end
        end
      end
    endcase
  endtask

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < N; i++) model_step(i);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        logic [3:0] exp_v, act_v;
        exp_v = {m_st[i] == S_FIRE, m_st[i] == S_ARM,
                 m_fir[i], m_flt[i]};
        act_v = {o_trig[i], o_armed[i], o_fired[i], o_fault[i]};
        checks++;
        if (act_v !== exp_v) begin
          failures++;
          $display("FAIL model u%0d cyc=%0d got=%b exp=%b",
                   i, cyc, act_v, exp_v);
        end
      end
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int len, input int gap);
    trig = 1'b1;
    ticks(len);
    trig = 1'b0;
    ticks(gap);
  endtask

  task automatic done_pulse();
    done = 1'b1;
    ticks(1);
    done = 1'b0;
  endtask

  initial begin
    #2ms;
    failures++;
    $display("FAIL watchdog cyc=%0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    int k, h, k0, k4;
    rst_n = 1'b0;
    trig  = 1'b0;
    done  = 1'b0;
    arm_v = '0;
    @(posedge clk);
    chk_en = 1;
    ticks(3);
    chk("rst_outs", {o_trig, o_armed, o_fired, o_fault}, 0);
    rst_n = 1'b1;

    // 1: default latency and done release
    ticks(1);
    arm_v[0] = 1'b1;
    ticks(3);
    chk("t1_armed", o_armed[0], 1);
    trig = 1'b1;
    k = 0;
    while (!o_trig[0] && k < 40) begin
      ticks(1);
      k++;
    end
    chk("t1_latency", k, 11);
    chk("t1_fired", o_fired[0], 1);
    ticks(19);
    trig = 1'b0;
    ticks(20);
    chk("t1_hold50", o_trig[0], 1);
    done_pulse();
    chk("t1_release", o_trig[0], 0);
    arm_v[0] = 1'b0;
    ticks(1040);

    // 2: saturated at arm, short spikes, exact-length pulse
    chk("t2_idle", o_armed[0], 0);
    trig = 1'b1;
    ticks(15);
    arm_v[0] = 1'b1;
    ticks(12);
    chk("t2_sat_nofire", o_trig[0], 0);
    chk("t2_fired_clr", o_fired[0], 0);
    trig = 1'b0;
    ticks(10);
    pulse(3, 10);
    pulse(5, 10);
    pulse(7, 10);
    chk("t2_spk_nofire", o_trig[0], 0);
    chk("t2_spk_armed", o_armed[0], 1);
    chk("t2_edge_cnt", g_dut[0].u_dut.edge_cnt, 0);
    pulse(8, 4);
    chk("t2_exact_fire", o_trig[0], 1);
    done_pulse();
    chk("t2_release", o_trig[0], 0);
    arm_v[0] = 1'b0;
    ticks(1040);

    // 3: EDGE_COUNT=3, arm drop discards count
    arm_v[1] = 1'b1;
    ticks(3);
    pulse(12, 10);
    chk("t3_p1", o_trig[1], 0);
    pulse(12, 10);
    chk("t3_p2", o_trig[1], 0);
    pulse(12, 10);
    chk("t3_p3", o_trig[1], 1);
    done_pulse();
    chk("t3_release", o_trig[1], 0);
    ticks(12);
    arm_v[1] = 1'b0;
    ticks(1);
    arm_v[1] = 1'b1;
    ticks(2);
    pulse(12, 10);
    pulse(12, 10);
    arm_v[1] = 1'b0;
    ticks(2);
    chk("t3_drop_idle", o_armed[1], 0);
    arm_v[1] = 1'b1;
    ticks(2);
    pulse(12, 10);
    chk("t3_rearm_nofire", o_trig[1], 0);
    chk("t3_fired_clr", o_fired[1], 0);
    arm_v[1] = 1'b0;
    ticks(2);

    // 4: holdoff with re-arm
    arm_v[2] = 1'b1;
    ticks(3);
    pulse(12, 4);
    chk("t4_fire", o_trig[2], 1);
    done_pulse();
    chk("t4_release", o_trig[2], 0);
    trig = 1'b1;
    ticks(12);
    chk("t4_ignored", o_trig[2], 0);
    chk("t4_hold_unarmed", o_armed[2], 0);
    trig = 1'b0;
    ticks(6);
    chk("t4_rearmed", o_armed[2], 1);
    pulse(12, 4);
    chk("t4_fire2", o_trig[2], 1);
    done_pulse();
    arm_v[2] = 1'b0;
    ticks(20);
    chk("t4_idle", o_armed[2], 0);

    // 5: done timeout
    arm_v[3] = 1'b1;
    ticks(3);
    trig = 1'b1;
    k = 0;
    while (!o_trig[3] && k < 40) begin
      ticks(1);
      k++;
    end
    chk("t5_latency", k, 11);
    trig = 1'b0;
    h = 0;
    while (o_trig[3] && h < 200) begin
      ticks(1);
      h++;
    end
    chk("t5_timeout", h, 100);
    chk("t5_fault", o_fault[3], 1);
    chk("t5_fired", o_fired[3], 1);
    ticks(1040);
    arm_v[3] = 1'b0;
    ticks(1);
    arm_v[3] = 1'b1;
    ticks(2);
    chk("t5_fault_clr", o_fault[3], 0);
    chk("t5_fired_clr", o_fired[3], 0);
    chk("t5_rearmed", o_armed[3], 1);
    arm_v[3] = 1'b0;
    ticks(2);

    // 6: INVERT timing, reset mid-FIRE
    arm_v[0] = 1'b1;
    arm_v[4] = 1'b1;
    ticks(3);
    trig = 1'b1;
    k = 0;
    k0 = 0;
    k4 = 0;
    while ((k0 == 0 || k4 == 0) && k < 40) begin
      ticks(1);
      k++;
      if (o_trig[0] && k0 == 0) k0 = k;
      if (o_trig[4] && k4 == 0) k4 = k;
    end
    chk("t6_lat_norm", k0, 11);
    chk("t6_lat_inv", k4, 11);
    rst_n = 1'b0;
    arm_v = '0;
    ticks(1);
    chk("t6_rst_outs", {o_trig, o_armed, o_fired, o_fault}, 0);
    rst_n = 1'b1;
    trig = 1'b0;
    ticks(2);
    pulse(12, 10);
    pulse(12, 10);
    chk("t6_nofire", o_trig, 0);
    chk("t6_unarmed", o_armed, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
